// File: rtl/draw_pkg.sv
// Shared types and constants for the screen drawing sequencer.
// Optional abort support is enabled by defining DRAW_ABORT_EN.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned SEL_W    = 7;
    localparam int unsigned ADDR_W   = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SWEEP,
        DRAIN,
        DONE
    } drawState_t;

    // Image indices (ROM images 0..72)
    localparam logic [SEL_W-1:0] TITLE1  = 7'd0;
    localparam logic [SEL_W-1:0] DOGDOG3 = 7'd72;

    // Row presets for the start row
    localparam logic [Y_W-1:0] Y_TOP    = 7'd0;
    localparam logic [Y_W-1:0] Y_BATTLE = 7'd30;

    // One pixel travelling through the ROM-latency delay line
    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_t;

    // y*160 + x as shift-add: 160 = 128 + 32, no multiplier needed
    function automatic logic [ADDR_W-1:0] pixAddr(input logic [X_W-1:0] px,
                                                  input logic [Y_W-1:0] py);
        logic [ADDR_W-1:0] yWide;
        logic [ADDR_W-1:0] xWide;
        yWide = ADDR_W'(py);
        xWide = ADDR_W'(px);
        return (yWide << 7) + (yWide << 5) + xWide;
    endfunction

endpackage

// File: rtl/draw_delay_line.sv
// Shift register carrying {valid, x, y} so plot/x/y line up with the image
// ROM read data. Depth equals the ROM read latency.
module draw_delay_line
    import draw_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  pix_t pixIn,
    output pix_t pixOut
);

    pix_t stage [DEPTH];

    // Shift one stage per cycle; reset flushes every in-flight pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= pixIn;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pixOut = stage[DEPTH-1];

endmodule

// File: rtl/screen_draw_ctrl.sv
// Pixel-drawing sequencer: accepts one draw request, sweeps the screen in
// raster order from the requested row, issues image ROM addresses and plots
// aligned to the ROM read latency, then pulses done.
// Define DRAW_ABORT_EN to add the draw_abort input.
module screen_draw_ctrl
    import draw_pkg::*;
#(
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              draw_req,
    input  logic [SEL_W-1:0]  draw_sel,
    input  logic [Y_W-1:0]    draw_y0,
    input  logic              draw_clear,
`ifdef DRAW_ABORT_EN
    input  logic              draw_abort,
`endif
    output logic              draw_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [SEL_W-1:0]  memorySel,
    output logic              black,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              plot
);

    drawState_t     state;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [Y_W-1:0] y0Lat;
    logic [1:0]     drainCnt;
    pix_t           issPix;
    pix_t           plotPix;

    // Sequencer FSM with registered handshake outputs and address issue stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            draw_ack  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            memorySel <= '0;
            black     <= 1'b0;
            y0Lat     <= '0;
            cx        <= '0;
            cy        <= '0;
            drainCnt  <= '0;
            rom_addr  <= '0;
            issPix    <= '0;
        end else begin
            draw_ack     <= 1'b0;
            busy         <= (state != IDLE);
            done         <= (state == DONE);
            issPix.valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (draw_req) begin
                        draw_ack  <= 1'b1;
                        memorySel <= draw_sel;
                        black     <= draw_clear;
                        y0Lat     <= draw_y0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    cx <= '0;
                    cy <= y0Lat;
                    // A start row below the screen draws nothing
                    if (y0Lat >= Y_W'(SCREEN_H)) begin
                        state <= DONE;
                    end else begin
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
`ifdef DRAW_ABORT_EN
                    if (draw_abort) begin
                        state    <= DRAIN;
                        drainCnt <= 2'(ROM_LAT - 1);
                    end else begin
`else
                    begin
`endif
                        rom_addr <= pixAddr(cx, cy);
                        issPix   <= '{valid: 1'b1, x: cx, y: cy};
                        if (cx == X_W'(SCREEN_W - 1)) begin
                            cx <= '0;
                            // Counters stop at the last pixel; never wrap past the screen
                            if (cy == Y_W'(SCREEN_H - 1)) begin
                                state    <= DRAIN;
                                drainCnt <= 2'(ROM_LAT - 1);
                            end else begin
                                cy <= cy + 1'b1;
                            end
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drainCnt == 2'd0) begin
                        state <= DONE;
                    end else begin
                        drainCnt <= drainCnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    draw_delay_line #(
        .DEPTH (ROM_LAT)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .pixIn  (issPix),
        .pixOut (plotPix)
    );

    assign plot = plotPix.valid;
    assign x    = plotPix.x;
    assign y    = plotPix.y;

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Directed bench for screen_draw_ctrl with hand-computed expectations.
module tb_screen_draw_ctrl;
    import draw_pkg::*;

    localparam int ROM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              draw_req;
    logic [SEL_W-1:0]  draw_sel;
    logic [Y_W-1:0]    draw_y0;
    logic              draw_clear;
`ifdef DRAW_ABORT_EN
    logic              draw_abort;
`endif
    logic              draw_ack;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [SEL_W-1:0]  memorySel;
    logic              black;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              plot;

    screen_draw_ctrl #(
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .draw_req   (draw_req),
        .draw_sel   (draw_sel),
        .draw_y0    (draw_y0),
        .draw_clear (draw_clear),
`ifdef DRAW_ABORT_EN
        .draw_abort (draw_abort),
`endif
        .draw_ack   (draw_ack),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .memorySel  (memorySel),
        .black      (black),
        .x          (x),
        .y          (y),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Per-draw observations
    int  tAck, tFirstPlot, tLastPlot, tDone;
    int  firstX, firstY, lastX, lastY, lastAddr, firstRom;
    int  nPlots, gaps, addrErr, selBad, blackBad, extraAck, busyCycles;
    int  wrapX, wrapY, wrapAddr;
    bit  gotAck, gotDone;
    logic [ADDR_W-1:0] romHist [0:20099];

    task automatic runDraw(input int sel, input int y0, input int clr,
                           input int nextSel, input bit holdReq);
        int prevX, prevY;
        bit prevPlot;
        draw_sel   = 7'(sel);
        draw_y0    = 7'(y0);
        draw_clear = clr[0];
        draw_req   = 1'b1;
        gotAck     = 1'b0;
        for (int i = 0; i < 10 && !gotAck; i++) begin
            @(negedge clk);
            if (draw_ack) begin
                gotAck = 1'b1;
                tAck   = cyc;
            end
        end
        if (!gotAck) begin
            checkVal("ack_timeout", 0, 1);
            draw_req = 1'b0;
            return;
        end
        if (holdReq) draw_sel = 7'(nextSel);
        else draw_req = 1'b0;
        nPlots = 0; gaps = 0; addrErr = 0; selBad = 0; blackBad = 0;
        extraAck = 0; busyCycles = 0; wrapX = -1; wrapY = -1; wrapAddr = -1;
        prevX = -1; prevY = -1; prevPlot = 1'b0; firstRom = -1; lastAddr = -1;
        romHist[0] = rom_addr;
        gotDone = 1'b0;
        for (int i = 1; i < 20100 && !gotDone; i++) begin
            @(negedge clk);
            romHist[i] = rom_addr;
            if (i == 2) firstRom = int'(rom_addr);
            if (busy) busyCycles++;
            if (draw_ack) extraAck++;
            if (memorySel != 7'(sel)) selBad++;
            if (black != clr[0]) blackBad++;
            if (plot) begin
                if (nPlots == 0) begin
                    tFirstPlot = cyc; firstX = int'(x); firstY = int'(y);
                end else if (!prevPlot) begin
                    gaps++;
                end
                if (prevPlot && prevX == 159 && prevY == y0) begin
                    wrapX = int'(x); wrapY = int'(y); wrapAddr = int'(romHist[i-ROM_LAT]);
                end
                if (i >= ROM_LAT && int'(romHist[i-ROM_LAT]) != int'(y) * 160 + int'(x))
                    addrErr++;
                lastX = int'(x); lastY = int'(y); tLastPlot = cyc;
                lastAddr = int'(romHist[i-ROM_LAT]);
                prevX = int'(x); prevY = int'(y);
                nPlots++;
            end
            prevPlot = plot;
            if (done) begin
                gotDone = 1'b1;
                tDone   = cyc;
            end
        end
        if (!gotDone) checkVal("done_timeout", 0, 1);
    endtask

    initial begin
        int prevDone, cnt;
        bit reached;
        reset = 1'b1; draw_req = 1'b0; draw_sel = '0; draw_y0 = '0; draw_clear = 1'b0;
`ifdef DRAW_ABORT_EN
        draw_abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_ack", int'(draw_ack), 0);
        checkVal("rst_busy", int'(busy), 0);
        checkVal("rst_done", int'(done), 0);
        checkVal("rst_plot", int'(plot), 0);
        checkVal("rst_black", int'(black), 0);
        checkVal("rst_addr", int'(rom_addr), 0);
        checkVal("rst_sel", int'(memorySel), 0);
        checkVal("rst_xy", int'(x) + int'(y), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full screen
        runDraw(0, 0, 0, 0, 1'b0);
        checkVal("full_first_plot_lat", tFirstPlot - tAck, 2 + ROM_LAT);
        checkVal("full_first_x", firstX, 0);
        checkVal("full_first_y", firstY, 0);
        checkVal("full_first_rom", firstRom, 0);
        checkVal("full_nplots", nPlots, 19200);
        checkVal("full_gaps", gaps, 0);
        checkVal("full_last_x", lastX, 159);
        checkVal("full_last_y", lastY, 119);
        checkVal("full_last_addr", lastAddr, 19199);
        checkVal("full_done_lat", tDone - tLastPlot, 1);
        checkVal("full_addr_err", addrErr, 0);
        checkVal("full_sel_bad", selBad, 0);
        checkVal("full_wrap_y", wrapY, 1);
        repeat (3) @(negedge clk);
        checkVal("idle_busy", int'(busy), 0);

        // Battle area
        runDraw(10, 30, 0, 0, 1'b0);
        checkVal("battle_first_rom", firstRom, 4800);
        checkVal("battle_first_y", firstY, 30);
        checkVal("battle_nplots", nPlots, 14400);
        checkVal("battle_wrap_x", wrapX, 0);
        checkVal("battle_wrap_y", wrapY, 31);
        checkVal("battle_wrap_addr", wrapAddr, 4960);
        checkVal("battle_addr_err", addrErr, 0);
        checkVal("battle_sel_bad", selBad, 0);
        repeat (2) @(negedge clk);

        // Clear to black
        runDraw(5, 0, 1, 0, 1'b0);
        checkVal("clear_black_bad", blackBad, 0);
        checkVal("clear_nplots", nPlots, 19200);
        checkVal("clear_sel_bad", selBad, 0);
        checkVal("clear_black_held", int'(black), 1);
        repeat (2) @(negedge clk);

        // Request held through a sweep with a new selection pending
        runDraw(20, 0, 0, 40, 1'b1);
        checkVal("hold_extra_ack", extraAck, 0);
        checkVal("hold_sel_bad", selBad, 0);
        prevDone = tDone;
        runDraw(40, 0, 0, 0, 1'b0);
        checkVal("hold_reack_lat", tAck - prevDone, 1);
        checkVal("hold_nplots", nPlots, 19200);
        checkVal("hold_sel40_bad", selBad, 0);
        repeat (2) @(negedge clk);

        // Start row off-screen
        runDraw(3, 120, 0, 0, 1'b0);
        checkVal("y120_nplots", nPlots, 0);
        checkVal("y120_busy", busyCycles, 2);
        checkVal("y120_done_lat", tDone - tAck, 2);
        repeat (2) @(negedge clk);

        // Reset in the middle of a sweep
        draw_sel = 7'd7; draw_y0 = '0; draw_clear = 1'b0; draw_req = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge clk);
            if (draw_ack) reached = 1'b1;
        end
        checkVal("rstmid_ack", int'(reached), 1);
        draw_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 500; i++) begin
            @(negedge clk);
            if (plot) cnt++;
        end
        checkVal("rstmid_reached500", cnt, 500);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("rstmid_plot", int'(plot), 0);
        checkVal("rstmid_busy", int'(busy), 0);
        checkVal("rstmid_sel", int'(memorySel), 0);
        checkVal("rstmid_addr", int'(rom_addr), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy || plot) cnt++;
        end
        checkVal("rstmid_quiet", cnt, 0);

        // Recovery: single last row
        runDraw(2, 119, 0, 0, 1'b0);
        checkVal("lastrow_nplots", nPlots, 160);
        checkVal("lastrow_y", lastY, 119);
        checkVal("lastrow_addr", lastAddr, 19199);

`ifdef DRAW_ABORT_EN
        repeat (2) @(negedge clk);
        draw_sel = 7'd9; draw_y0 = '0; draw_req = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge clk);
            if (draw_ack) reached = 1'b1;
        end
        draw_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 500; i++) begin
            @(negedge clk);
            if (plot) cnt++;
        end
        draw_abort = 1'b1;
        @(negedge clk);
        draw_abort = 1'b0;
        cnt = 0;
        reached = 1'b0;
        if (plot) cnt++;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk);
            if (plot) cnt++;
            if (done) reached = 1'b1;
        end
        checkVal("abort_extra_plots", cnt, ROM_LAT);
        checkVal("abort_done", int'(reached), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
